// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types for the two-requester bus arbiter.
//   arb_state_t : IDLE / ISSUE / WAIT transaction phases
//   owner_t     : which requester owns the outstanding transaction
//   bus_req_t   : registered bus request payload (addr, write, wdata, wstrb)
// The payload struct is sized by BUS_ADDR_W / BUS_DATA_W. The arbiter's
// ADDR_W / DATA_W parameters default to these. Change both places together.
package bus_arb_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_F = 1'b0,
    OWNER_L = 1'b1
  } owner_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic                  write;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_STRB_W-1:0] wstrb;
  } bus_req_t;

endpackage

// File: rtl/bus_arb_pick.sv
// bus_arb_pick: purely combinational winner select between fetch (F) and
// load/store (L).
// Configuration macro: BUS_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, L beats F on contention
//   defined   : on contention the requester not granted last wins
//               (last_grant port exists only in this build)
// Ports:
//   f_valid, l_valid : request valids
//   last_grant       : previous winner (round-robin build only)
//   winner           : selected owner (meaningful when any valid is set)
//   grant_f, grant_l : valid AND selected, per requester
module bus_arb_pick
  import bus_arb_pkg::*;
(
  input  logic   f_valid,
  input  logic   l_valid,
`ifdef BUS_ARB_ROUND_ROBIN_EN
  input  owner_t last_grant,
`endif
  output owner_t winner,
  output logic   grant_f,
  output logic   grant_l
);

  always_comb begin
    winner = OWNER_L;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    if (f_valid && l_valid) begin
      winner = (last_grant == OWNER_F) ? OWNER_L : OWNER_F;
    end else if (f_valid) begin
      winner = OWNER_F;
    end
`else
    // F only wins when L is not asking.
    if (f_valid && !l_valid) begin
      winner = OWNER_F;
    end
`endif
  end

  assign grant_f = f_valid && (winner == OWNER_F);
  assign grant_l = l_valid && (winner == OWNER_L);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one bus-master port between instruction fetch (F) and
// load/store (L). One transaction at a time is latched into a single slot,
// issued on the bus, and its response is routed back to the owner.
// Configuration macro: BUS_ARB_ROUND_ROBIN_EN (round-robin arbitration with a
// last_grant register; default build uses fixed L-over-F priority).
// Parameters: ADDR_W, DATA_W, TIMEOUT (WAIT cycles before an error response,
//   0 disables the timeout).
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   f_req_* / f_rsp_*            : fetch request (read only) and response
//   l_req_* / l_rsp_*            : load/store request and response
//   bus_req_* / bus_rsp_*        : external bus request and response
//   busy                         : a transaction is in flight
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int          ADDR_W  = BUS_ADDR_W,
  parameter int          DATA_W  = BUS_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                f_req_valid,
  output logic                f_req_ready,
  input  logic [ADDR_W-1:0]   f_req_addr,
  output logic                f_rsp_valid,
  output logic [DATA_W-1:0]   f_rsp_rdata,
  output logic                f_rsp_err,
  input  logic                l_req_valid,
  output logic                l_req_ready,
  input  logic [ADDR_W-1:0]   l_req_addr,
  input  logic                l_req_write,
  input  logic [DATA_W-1:0]   l_req_wdata,
  input  logic [DATA_W/8-1:0] l_req_wstrb,
  output logic                l_rsp_valid,
  output logic [DATA_W-1:0]   l_rsp_rdata,
  output logic                l_rsp_err,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic                bus_req_write,
  output logic [DATA_W-1:0]   bus_req_wdata,
  output logic [DATA_W/8-1:0] bus_req_wstrb,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rsp_rdata,
  output logic                busy
);

  arb_state_t state_reg, state_next;
  owner_t     owner_reg, owner_next;
  bus_req_t   payload_reg, payload_next;

  owner_t winner;
  logic   grant_f;
  logic   grant_l;
  logic   timeout_hit;
  logic   rsp_fire;
  logic   rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_valid_vec;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  owner_t last_grant_reg, last_grant_next;
`endif

  bus_arb_pick u_pick (
    .f_valid    (f_req_valid),
    .l_valid    (l_req_valid),
`ifdef BUS_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_reg),
`endif
    .winner     (winner),
    .grant_f    (grant_f),
    .grant_l    (grant_l)
  );

  // Next-state and payload capture.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    payload_next = payload_reg;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    last_grant_next = last_grant_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (f_req_valid || l_req_valid) begin
          owner_next = winner;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_grant_next = winner;
`endif
          if (winner == OWNER_L) begin
            payload_next = '{addr: l_req_addr, write: l_req_write,
                             wdata: l_req_wdata, wstrb: l_req_wstrb};
          end else begin
            // Fetches are always reads with no strobes.
            payload_next = '{addr: f_req_addr, write: 1'b0,
                             wdata: '0, wstrb: '0};
          end
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (rsp_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      owner_reg   <= OWNER_F;
      payload_reg <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      payload_reg <= payload_next;
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= OWNER_F;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end
`endif

  // Response timeout. The counter holds the number of WAIT cycles already
  // spent without a response; it fires on the TIMEOUT-th WAIT cycle.
  generate
    if (TIMEOUT != 0) begin : g_timeout
      localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] count_reg;

      assign timeout_hit = (state_reg == WAIT) && (count_reg == CNT_LAST);

      always_ff @(posedge clock) begin
        if (reset) begin
          count_reg <= '0;
        end else if (state_reg == ISSUE && bus_req_ready) begin
          count_reg <= '0;
        end else if (state_reg == WAIT && !bus_rsp_valid && !timeout_hit) begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // A real response in the timeout cycle takes precedence over the error.
  assign rsp_fire  = (state_reg == WAIT) && (bus_rsp_valid || timeout_hit);
  assign rsp_err   = !bus_rsp_valid;
  assign rsp_rdata = bus_rsp_valid ? bus_rsp_rdata : '0;

  // Response steering: index 0 is F, index 1 is L.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_valid_vec[gi] =
        rsp_fire && (owner_reg == ((gi == 1) ? OWNER_L : OWNER_F));
    end
  endgenerate

  assign f_rsp_valid = rsp_valid_vec[0];
  assign l_rsp_valid = rsp_valid_vec[1];
  assign f_rsp_rdata = rsp_rdata;
  assign l_rsp_rdata = rsp_rdata;
  assign f_rsp_err   = rsp_valid_vec[0] && rsp_err;
  assign l_rsp_err   = rsp_valid_vec[1] && rsp_err;

  assign f_req_ready = (state_reg == IDLE) && grant_f;
  assign l_req_ready = (state_reg == IDLE) && grant_l;

  assign bus_req_valid = (state_reg == ISSUE);
  assign bus_req_addr  = payload_reg.addr;
  assign bus_req_write = payload_reg.write;
  assign bus_req_wdata = payload_reg.wdata;
  assign bus_req_wstrb = payload_reg.wstrb;

  assign busy = (state_reg != IDLE);

  // The bus must not answer before it has accepted the request.
  a_no_rsp_in_issue: assert property (@(posedge clock) disable iff (reset)
    !(state_reg == ISSUE && bus_rsp_valid));

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter (TIMEOUT = 4).
// Table of transactions for the directed cases, hand sequences for reset in
// WAIT and back-to-back contention, then random transactions whose expected
// winner, payload and response come from a rule-level reference model.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clock;
  logic          reset;
  logic          f_req_valid;
  logic          f_req_ready;
  logic [AW-1:0] f_req_addr;
  logic          f_rsp_valid;
  logic [DW-1:0] f_rsp_rdata;
  logic          f_rsp_err;
  logic          l_req_valid;
  logic          l_req_ready;
  logic [AW-1:0] l_req_addr;
  logic          l_req_write;
  logic [DW-1:0] l_req_wdata;
  logic [SW-1:0] l_req_wstrb;
  logic          l_rsp_valid;
  logic [DW-1:0] l_rsp_rdata;
  logic          l_rsp_err;
  logic          bus_req_valid;
  logic          bus_req_ready;
  logic [AW-1:0] bus_req_addr;
  logic          bus_req_write;
  logic [DW-1:0] bus_req_wdata;
  logic [SW-1:0] bus_req_wstrb;
  logic          bus_rsp_valid;
  logic [DW-1:0] bus_rsp_rdata;
  logic          busy;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .f_req_valid   (f_req_valid),
    .f_req_ready   (f_req_ready),
    .f_req_addr    (f_req_addr),
    .f_rsp_valid   (f_rsp_valid),
    .f_rsp_rdata   (f_rsp_rdata),
    .f_rsp_err     (f_rsp_err),
    .l_req_valid   (l_req_valid),
    .l_req_ready   (l_req_ready),
    .l_req_addr    (l_req_addr),
    .l_req_write   (l_req_write),
    .l_req_wdata   (l_req_wdata),
    .l_req_wstrb   (l_req_wstrb),
    .l_rsp_valid   (l_rsp_valid),
    .l_rsp_rdata   (l_rsp_rdata),
    .l_rsp_err     (l_rsp_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_addr  (bus_req_addr),
    .bus_req_write (bus_req_write),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_wstrb (bus_req_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit last_l = 1'b0;   // model: previous winner was L (reset value F)

  typedef struct {
    bit            fv;
    bit            lv;
    logic [AW-1:0] fa;
    logic [AW-1:0] la;
    bit            lw;
    logic [DW-1:0] lwd;
    logic [SW-1:0] ls;
    int            rdy_dly;   // ISSUE cycles with bus_req_ready low
    int            rsp_dly;   // WAIT cycles before bus_rsp_valid
    logic [DW-1:0] rdata;
    bit            idle_junk; // spurious bus_rsp_valid while IDLE
    bit            exp_l;     // expected winner is L
  } txn_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arbitration rule.
  function automatic bit model_pick_l(bit fv, bit lv, bit prev_l);
    if (fv && !lv) return 1'b0;
    if (lv && !fv) return 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    return !prev_l;
`else
    return (prev_l || !prev_l);
`endif
  endfunction

  function automatic txn_t mk(bit fv, bit lv, logic [AW-1:0] fa, logic [AW-1:0] la,
                              bit lw, logic [DW-1:0] lwd, logic [SW-1:0] ls,
                              int rdy, int rsp, logic [DW-1:0] rd, bit junk, bit el);
    txn_t t;
    t.fv = fv; t.lv = lv; t.fa = fa; t.la = la; t.lw = lw; t.lwd = lwd; t.ls = ls;
    t.rdy_dly = rdy; t.rsp_dly = rsp; t.rdata = rd; t.idle_junk = junk; t.exp_l = el;
    return t;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one full transaction; inputs change at posedge+1, outputs sampled
  // at posedge+5.
  task automatic run_txn(input txn_t t, input bit exp_l, input string tag);
    int  resp_idx;
    bit  timed;
    logic [AW-1:0] e_addr;
    logic          e_write;
    logic [SW-1:0] e_strb;
    e_addr  = exp_l ? t.la : t.fa;
    e_write = exp_l ? t.lw : 1'b0;
    e_strb  = exp_l ? t.ls : '0;
    timed    = (t.rsp_dly >= TO);
    resp_idx = timed ? TO - 1 : t.rsp_dly;

    f_req_valid = t.fv; f_req_addr = t.fa;
    l_req_valid = t.lv; l_req_addr = t.la; l_req_write = t.lw;
    l_req_wdata = t.lwd; l_req_wstrb = t.ls;
    bus_req_ready = 1'b0;
    bus_rsp_valid = t.idle_junk; bus_rsp_rdata = $urandom;
    #4;
    chk({tag, " f_req_ready"}, f_req_ready, t.fv && !exp_l);
    chk({tag, " l_req_ready"}, l_req_ready, t.lv && exp_l);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle rsp"}, {f_rsp_valid, l_rsp_valid}, 0);
    tick();
    if (exp_l) l_req_valid = 1'b0; else f_req_valid = 1'b0;
    bus_rsp_valid = 1'b0;

    for (int i = 0; i <= t.rdy_dly; i++) begin
      bus_req_ready = (i == t.rdy_dly);
      #4;
      chk({tag, " issue valid"}, bus_req_valid, 1);
      chk({tag, " issue addr"}, bus_req_addr, e_addr);
      chk({tag, " issue write"}, bus_req_write, e_write);
      chk({tag, " issue wstrb"}, bus_req_wstrb, e_strb);
      if (exp_l) chk({tag, " issue wdata"}, bus_req_wdata, t.lwd);
      chk({tag, " issue busy/ready"}, {busy, f_req_ready, l_req_ready}, 3'b100);
      tick();
    end
    bus_req_ready = 1'b0;

    for (int k = 0; k <= resp_idx; k++) begin
      bus_rsp_valid = (k == t.rsp_dly);
      bus_rsp_rdata = (k == t.rsp_dly) ? t.rdata : DW'($urandom);
      #4;
      if (k < resp_idx) begin
        chk({tag, " wait quiet"}, {f_rsp_valid, l_rsp_valid, bus_req_valid, busy}, 4'b0001);
      end else begin
        chk({tag, " f_rsp_valid"}, f_rsp_valid, !exp_l);
        chk({tag, " l_rsp_valid"}, l_rsp_valid, exp_l);
        chk({tag, " rsp_rdata"}, exp_l ? l_rsp_rdata : f_rsp_rdata, timed ? '0 : t.rdata);
        chk({tag, " rsp_err"}, exp_l ? l_rsp_err : f_rsp_err, timed);
      end
      tick();
    end
    bus_rsp_valid = 1'b0;
  endtask

  txn_t tbl[7];
  bit   rr_exp[6];

  initial begin
    reset = 1'b1;
    f_req_valid = 0; f_req_addr = '0; l_req_valid = 0; l_req_addr = '0;
    l_req_write = 0; l_req_wdata = '0; l_req_wstrb = '0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = '0;

    //         fv lv fa        la        lw wdata         strb  rdy rsp rdata         junk expL
    tbl[0] = mk(1, 0, 32'h100, 32'h0,    0, 32'h0,        4'h0, 0,  1,  32'hDEADBEEF, 0,   0);
    tbl[1] = mk(1, 1, 32'h300, 32'h200,  1, 32'h12345678, 4'hF, 0,  0,  32'h0000AAAA, 0,   1);
    tbl[2] = mk(1, 0, 32'h300, 32'h0,    0, 32'h0,        4'h0, 5,  2,  32'hCAFEF00D, 0,   0);
    tbl[3] = mk(0, 1, 32'h0,   32'h400,  0, 32'h0,        4'h0, 1,  4,  32'h11111111, 0,   1);
    tbl[4] = mk(1, 0, 32'h500, 32'h0,    0, 32'h0,        4'h0, 0,  3,  32'h5A5A5A5A, 0,   0);
    tbl[5] = mk(1, 1, 32'h600, 32'h700,  1, 32'h87654321, 4'h3, 2,  6,  32'h22222222, 0,   1);
    tbl[6] = mk(1, 0, 32'h800, 32'h0,    0, 32'h0,        4'h0, 0,  0,  32'h33333333, 1,   0);

`ifdef BUS_ARB_ROUND_ROBIN_EN
    rr_exp = '{1, 0, 1, 0, 1, 0};
`else
    rr_exp = '{1, 1, 1, 1, 1, 1};
`endif

    repeat (3) tick();
    #4;
    chk("reset valids", {busy, bus_req_valid, f_req_ready, l_req_ready,
                         f_rsp_valid, l_rsp_valid, f_rsp_err, l_rsp_err}, 0);
    chk("reset payload", {bus_req_addr, bus_req_write, bus_req_wstrb}, 0);
    chk("reset wdata", bus_req_wdata, 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], tbl[i].exp_l, $sformatf("tbl%0d", i));
      last_l = tbl[i].exp_l;
    end

    // Reset while waiting for a response, then a late response.
    f_req_valid = 1; f_req_addr = 32'h900;
    tick();
    f_req_valid = 0; bus_req_ready = 1;
    tick();
    bus_req_ready = 0;
    #4;
    chk("rst_wait busy", busy, 1);
    tick();
    reset = 1'b1;
    tick();
    last_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) reset = 1'b0;
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hBADBAD00;
      #4;
      chk($sformatf("rst_wait quiet%0d", i),
          {f_rsp_valid, l_rsp_valid, busy, bus_req_valid, f_req_ready, l_req_ready}, 0);
      tick();
    end
    bus_rsp_valid = 1'b0;

    // Both requesters continuously valid for six transactions.
    for (int i = 0; i < 6; i++) begin
      txn_t t;
      t = mk(1, 1, 32'h1000 + i, 32'h2000 + i, 0, 32'h0, 4'h0, 0, 0, 32'hA0 + i, 0, rr_exp[i]);
      run_txn(t, rr_exp[i], $sformatf("contend%0d", i));
      last_l = rr_exp[i];
    end

    // Random transactions against the model.
    for (int i = 0; i < 40; i++) begin
      txn_t t;
      bit   fv, lv;
      fv = 1'($urandom); lv = 1'($urandom);
      if (!fv && !lv) lv = 1'b1;
      t = mk(fv, lv, $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 6), $urandom, 1'($urandom), 1'b0);
      t.exp_l = model_pick_l(fv, lv, last_l);
      run_txn(t, t.exp_l, $sformatf("rand%0d", i));
      last_l = t.exp_l;
      f_req_valid = 0; l_req_valid = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
